// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared stall/bus widths, ALU op indices, SPECIAL function codes and divider FSM states
package ex_stage_pkg;
  localparam int STALL_BUS = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int ID_TO_EX_WD = 160;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD = 38;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_SLT = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND = 4;
  localparam int OP_NOR = 5;
  localparam int OP_OR = 6;
  localparam int OP_XOR = 7;
  localparam int OP_SLL = 8;
  localparam int OP_SRL = 9;
  localparam int OP_SRA = 10;
  localparam int OP_LUI = 11;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_DIV = 6'h1a;
  localparam logic [5:0] FN_DIVU = 6'h1b;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
  function automatic logic is_special(input logic [31:0] inst, input logic [5:0] fn);
    return inst[31:26] == 6'd0 && inst[5:0] == fn;
  endfunction
endpackage

// File: rtl/ex_stage_div.sv
// div_iter: 32-cycle restoring divider (start/ack handshake, signed_op, a/b in; busy/done, quotient/remainder out)
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ack,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  div_state_t state;
  logic [4:0] cnt;
  logic [31:0] r, q, d, abs_a, abs_b;
  logic neg_q, neg_r, ge;
  logic [32:0] r_sh, diff;
  assign abs_a = signed_op && a[31] ? -a : a;
  assign abs_b = signed_op && b[31] ? -b : b;
  assign r_sh = {r, q[31]};
  assign diff = r_sh - {1'b0, d};
  assign ge = ~diff[32];
  assign quotient = neg_q ? -q : q;
  assign remainder = neg_r ? -r : r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= DIV_IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else
      case (state)
        DIV_IDLE: if (start) begin
          state <= DIV_BUSY;
          busy <= 1'b1;
          cnt <= '0;
          r <= '0;
          q <= abs_a;
          d <= abs_b;
          neg_q <= signed_op & (a[31] ^ b[31]) & (|b);
          neg_r <= signed_op & a[31];
        end
        DIV_BUSY: begin
          r <= ge ? diff[31:0] : r_sh[31:0];
          q <= {q[30:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DIV_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DIV_DONE: if (ack) begin
          state <= DIV_IDLE;
          done <= 1'b0;
        end
        default: begin
          state <= DIV_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
endmodule

// File: rtl/ex_stage.sv
// ex_stage: EX pipe stage (clk/rst, stall, id_to_ex_bus in; ex_to_mem_bus, ex_to_rf_bus, data_sram_*, stallreq_for_ex out) with ALU, HI/LO and divider
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);
  logic [ID_TO_EX_WD-1:0] bus;
  logic mem_op, ram_en, bus_rf_we, sel_rf_res, rf_we, advance, unused;
  logic [31:0] pc, inst, rdata1, rdata2, imm_s, imm_z, src1, src2, alu_res, ex_result, hi, lo, quotient, remainder;
  logic [11:0] alu_op;
  logic [2:0] sel_src1;
  logic [3:0] sel_src2, ram_wen;
  logic [4:0] bus_rf_waddr, rf_waddr;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, div_busy, div_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) bus <= '0;
    else if (stall[2] == STOP && stall[3] == NO_STOP) bus <= '0;
    else if (stall[2] == NO_STOP) bus <= id_to_ex_bus;
  assign {mem_op, pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, bus_rf_we, bus_rf_waddr, sel_rf_res, rdata1, rdata2} = bus;
  assign advance = stall[2] == NO_STOP;
  assign unused = ^{stall[5:4], stall[1:0], inst[25:16]};
  assign imm_s = {{16{inst[15]}}, inst[15:0]};
  assign imm_z = {16'd0, inst[15:0]};
  assign src1 = ({32{sel_src1[0]}} & rdata1) | ({32{sel_src1[1]}} & pc) | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2) | ({32{sel_src2[1]}} & imm_s) | ({32{sel_src2[2]}} & 32'd8) | ({32{sel_src2[3]}} & imm_z);
  assign alu_res = ({32{alu_op[OP_ADD]}} & (src1 + src2))
                 | ({32{alu_op[OP_SUB]}} & (src1 - src2))
                 | ({32{alu_op[OP_SLT]}} & {31'd0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[OP_SLTU]}} & {31'd0, src1 < src2})
                 | ({32{alu_op[OP_AND]}} & (src1 & src2))
                 | ({32{alu_op[OP_NOR]}} & ~(src1 | src2))
                 | ({32{alu_op[OP_OR]}} & (src1 | src2))
                 | ({32{alu_op[OP_XOR]}} & (src1 ^ src2))
                 | ({32{alu_op[OP_SLL]}} & (src2 << src1[4:0]))
                 | ({32{alu_op[OP_SRL]}} & (src2 >> src1[4:0]))
                 | ({32{alu_op[OP_SRA]}} & 32'($signed(src2) >>> src1[4:0]))
                 | ({32{alu_op[OP_LUI]}} & {src2[15:0], 16'd0});
  assign is_mfhi = is_special(inst, FN_MFHI);
  assign is_mflo = is_special(inst, FN_MFLO);
  assign is_mthi = is_special(inst, FN_MTHI);
  assign is_mtlo = is_special(inst, FN_MTLO);
  assign is_div = is_special(inst, FN_DIV) | is_special(inst, FN_DIVU);
  div_iter u_div (
    .clk(clk),
    .rst(rst),
    .start(is_div),
    .ack(advance),
    .signed_op(is_special(inst, FN_DIV)),
    .a(rdata1),
    .b(rdata2),
    .busy(div_busy),
    .done(div_done),
    .quotient(quotient),
    .remainder(remainder)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (advance) begin
      if (div_done) begin
        hi <= remainder;
        lo <= quotient;
      end
      if (is_mthi) hi <= rdata1;
      if (is_mtlo) lo <= rdata1;
    end
  assign stallreq_for_ex = div_busy | (is_div & ~div_done);
  assign ex_result = is_mfhi ? hi : is_mflo ? lo : alu_res;
  assign rf_we = is_mfhi | is_mflo | bus_rf_we;
  assign rf_waddr = is_mfhi | is_mflo ? inst[15:11] : bus_rf_waddr;
  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus = {rf_we, rf_waddr, ex_result};
  assign data_sram_en = ram_en | mem_op;
  assign data_sram_wen = ram_wen;
  assign data_sram_addr = rdata1 + imm_s;
  assign data_sram_wdata = rdata2;
endmodule
